// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use bubble insertion and branch flush
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [7:0]        id_ctrl_i,
    input  logic [3:0]        id_alu_instr_i,
    input  logic [DATA_W-1:0] id_rs1_data_i,
    input  logic [DATA_W-1:0] id_rs2_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [DATA_W-1:0] id_pc_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    output logic [7:0]        ex_ctrl_o,
    output logic [3:0]        ex_alu_instr_o,
    output logic [DATA_W-1:0] ex_rs1_data_o,
    output logic [DATA_W-1:0] ex_rs2_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [DATA_W-1:0] ex_pc_o,
    output logic [REG_AW-1:0] ex_rs1_o,
    output logic [REG_AW-1:0] ex_rs2_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              hazard_stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic load_use;
    logic bubble;

    // rs2 is matched for every instruction type; a few false stalls are cheaper than decoding usage
    assign load_use = ex_valid_o & ex_ctrl_o[5] & (ex_rd_o != '0) & id_valid_i &
                      ((ex_rd_o == id_rs1_i) | (ex_rd_o == id_rs2_i));

    assign hazard_stall_o = load_use & ~flush_i;
    assign bubble         = flush_i | load_use;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_o     <= 1'b0;
            ex_ctrl_o      <= '0;
            ex_alu_instr_o <= '0;
            ex_rs1_data_o  <= '0;
            ex_rs2_data_o  <= '0;
            ex_imm_o       <= '0;
            ex_pc_o        <= '0;
            ex_rs1_o       <= '0;
            ex_rs2_o       <= '0;
            ex_rd_o        <= '0;
            bubble_cnt_o   <= '0;
        end else if (bubble) begin
            ex_valid_o     <= 1'b0;
            ex_ctrl_o      <= '0;
            ex_alu_instr_o <= '0;
            ex_rs1_data_o  <= '0;
            ex_rs2_data_o  <= '0;
            ex_imm_o       <= '0;
            ex_pc_o        <= '0;
            ex_rs1_o       <= '0;
            ex_rs2_o       <= '0;
            ex_rd_o        <= '0;
            // a flushed slot is not a load-use bubble, so only count when the stall is real
            if (hazard_stall_o && (bubble_cnt_o != '1)) begin
                bubble_cnt_o <= bubble_cnt_o + 1'b1;
            end
        end else begin
            ex_valid_o     <= id_valid_i;
            ex_ctrl_o      <= id_valid_i ? id_ctrl_i : 8'h00;
            ex_alu_instr_o <= id_alu_instr_i;
            ex_rs1_data_o  <= id_rs1_data_i;
            ex_rs2_data_o  <= id_rs2_data_i;
            ex_imm_o       <= id_imm_i;
            ex_pc_o        <= id_pc_i;
            ex_rs1_o       <= id_rs1_i;
            ex_rs2_o       <= id_rs2_i;
            ex_rd_o        <= id_rd_i;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - table-driven scoreboard bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [7:0]  id_ctrl;
    logic [3:0]  id_alu;
    logic [31:0] id_rs1d, id_rs2d, id_imm, id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        flush;

    logic        ex_valid, s_valid;
    logic [7:0]  ex_ctrl, s_ctrl;
    logic [3:0]  ex_alu, s_alu;
    logic [31:0] ex_rs1d, ex_rs2d, ex_imm, ex_pc;
    logic [31:0] s_rs1d, s_rs2d, s_imm, s_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, s_rs1, s_rs2, s_rd;
    logic        stall, s_stall;
    logic [15:0] cnt;
    logic [1:0]  s_cnt;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_ctrl_i(id_ctrl),
        .id_alu_instr_i(id_alu), .id_rs1_data_i(id_rs1d), .id_rs2_data_i(id_rs2d),
        .id_imm_i(id_imm), .id_pc_i(id_pc), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rd_i(id_rd), .flush_i(flush), .ex_valid_o(ex_valid), .ex_ctrl_o(ex_ctrl),
        .ex_alu_instr_o(ex_alu), .ex_rs1_data_o(ex_rs1d), .ex_rs2_data_o(ex_rs2d),
        .ex_imm_o(ex_imm), .ex_pc_o(ex_pc), .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2),
        .ex_rd_o(ex_rd), .hazard_stall_o(stall), .bubble_cnt_o(cnt)
    );

    id_ex_stage_reg #(.CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_ctrl_i(id_ctrl),
        .id_alu_instr_i(id_alu), .id_rs1_data_i(id_rs1d), .id_rs2_data_i(id_rs2d),
        .id_imm_i(id_imm), .id_pc_i(id_pc), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rd_i(id_rd), .flush_i(flush), .ex_valid_o(s_valid), .ex_ctrl_o(s_ctrl),
        .ex_alu_instr_o(s_alu), .ex_rs1_data_o(s_rs1d), .ex_rs2_data_o(s_rs2d),
        .ex_imm_o(s_imm), .ex_pc_o(s_pc), .ex_rs1_o(s_rs1), .ex_rs2_o(s_rs2),
        .ex_rd_o(s_rd), .hazard_stall_o(s_stall), .bubble_cnt_o(s_cnt)
    );

    typedef struct packed {
        logic        valid;
        logic [7:0]  ctrl;
        logic [3:0]  alu;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        flush;
        logic        exp_stall;
        logic        exp_bubble;
        logic [15:0] exp_cnt;
        logic [1:0]  exp_cnt_sat;
    } vec_t;

    typedef struct packed {
        logic [155:0] bus;
        logic [15:0]  cnt;
        logic [1:0]   cnt_sat;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t rvecs[$];
    exp_t sb[$];

    function automatic vec_t mk(logic v, logic [7:0] c, logic [3:0] a, logic [31:0] d1, logic [31:0] d2,
                                logic [4:0] r1, logic [4:0] r2, logic [4:0] rd, logic f,
                                logic st, logic bb, logic [15:0] ec, logic [1:0] es);
        vec_t t;
        t = '{v, c, a, d1, d2, r1, r2, rd, f, st, bb, ec, es};
        return t;
    endfunction

    function automatic logic [155:0] act_bus();
        return {ex_valid, ex_ctrl, ex_alu, ex_rs1d, ex_rs2d, ex_imm, ex_pc, ex_rs1, ex_rs2, ex_rd};
    endfunction

    task automatic check(input string name, input logic [155:0] act, input logic [155:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_bus"}, act_bus(), '0);
        check({name, "_cnt"}, {140'd0, cnt}, '0);
        check({name, "_cnt_sat"}, {154'd0, s_cnt}, '0);
        check({name, "_stall"}, {155'd0, stall}, '0);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        id_valid = v.valid; id_ctrl = v.ctrl; id_alu = v.alu;
        id_rs1d = v.rs1d; id_rs2d = v.rs2d;
        id_imm = v.rs1d ^ 32'h55; id_pc = 32'h400 + v.rs2d;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd; flush = v.flush;
        @(negedge clk);
        check($sformatf("stall_v%0d", idx), {155'd0, stall}, {155'd0, v.exp_stall});
        if (v.exp_bubble) e.bus = '0;
        else e.bus = {v.valid, (v.valid ? v.ctrl : 8'h00), v.alu, v.rs1d, v.rs2d,
                      v.rs1d ^ 32'h55, 32'h400 + v.rs2d, v.rs1, v.rs2, v.rd};
        e.cnt = v.exp_cnt;
        e.cnt_sat = v.exp_cnt_sat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty_v%0d actual=0 required=1", idx);
        end else begin
            got = sb.pop_front();
            check($sformatf("ex_bus_v%0d", idx), act_bus(), got.bus);
            check($sformatf("cnt_v%0d", idx), {140'd0, cnt}, {140'd0, got.cnt});
            check($sformatf("cnt_sat_v%0d", idx), {154'd0, s_cnt}, {154'd0, got.cnt_sat});
        end
    endtask

    initial begin
        // stall expectations, bubble flags and counts are hand-derived per row
        vecs.push_back(mk(1, 8'h82, 4'h8, 5,   3,  1,  2,  7,  0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'hE4, 4'h2, 100, 0,  3,  0,  5,  0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'h82, 4'h0, 11,  12, 5,  6,  8,  0, 1, 1, 1, 1));
        vecs.push_back(mk(1, 8'h82, 4'h0, 11,  12, 5,  6,  8,  0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 8'hE4, 4'h2, 20,  0,  2,  0,  0,  0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 8'h82, 4'h0, 21,  22, 0,  0,  4,  0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 8'hE4, 4'h2, 30,  0,  1,  2,  9,  0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 8'h82, 4'h0, 31,  32, 1,  9,  10, 0, 1, 1, 2, 2));
        vecs.push_back(mk(1, 8'h82, 4'h0, 31,  32, 1,  9,  10, 0, 0, 0, 2, 2));
        vecs.push_back(mk(1, 8'hE4, 4'h2, 40,  0,  4,  0,  11, 0, 0, 0, 2, 2));
        vecs.push_back(mk(1, 8'h82, 4'h0, 41,  42, 11, 1,  12, 1, 0, 1, 2, 2));
        vecs.push_back(mk(0, 8'hFF, 4'hF, 50,  51, 6,  7,  3,  0, 0, 0, 2, 2));
        vecs.push_back(mk(1, 8'h82, 4'h0, 52,  53, 3,  3,  12, 0, 0, 0, 2, 2));
        vecs.push_back(mk(1, 8'hE4, 4'h2, 60,  0,  1,  0,  13, 0, 0, 0, 2, 2));
        vecs.push_back(mk(0, 8'h82, 4'h0, 61,  62, 13, 13, 14, 0, 0, 0, 2, 2));
        vecs.push_back(mk(1, 8'hE4, 4'h2, 70,  0,  1,  0,  5,  0, 0, 0, 2, 2));
        vecs.push_back(mk(1, 8'h82, 4'h0, 71,  72, 5,  1,  15, 0, 1, 1, 3, 3));
        vecs.push_back(mk(1, 8'h82, 4'h0, 71,  72, 5,  1,  15, 0, 0, 0, 3, 3));
        vecs.push_back(mk(1, 8'hE4, 4'h2, 80,  0,  1,  0,  6,  0, 0, 0, 3, 3));
        vecs.push_back(mk(1, 8'h82, 4'h0, 81,  82, 1,  6,  16, 0, 1, 1, 4, 3));
        vecs.push_back(mk(1, 8'h82, 4'h0, 81,  82, 1,  6,  16, 0, 0, 0, 4, 3));
        vecs.push_back(mk(1, 8'hE4, 4'h2, 90,  0,  1,  0,  7,  0, 0, 0, 4, 3));
        vecs.push_back(mk(1, 8'h82, 4'h0, 91,  92, 7,  2,  17, 0, 1, 1, 5, 3));
        vecs.push_back(mk(1, 8'h82, 4'h0, 91,  92, 7,  2,  17, 0, 0, 0, 5, 3));

        rvecs.push_back(mk(1, 8'hE4, 4'h2, 200, 0,   1, 0, 5,  0, 0, 0, 0, 0));
        rvecs.push_back(mk(1, 8'h82, 4'h0, 201, 202, 5, 2, 20, 0, 1, 1, 1, 1));
        rvecs.push_back(mk(1, 8'h82, 4'h0, 201, 202, 5, 2, 20, 0, 0, 0, 1, 1));
        rvecs.push_back(mk(1, 8'hE4, 4'h2, 210, 0,   1, 0, 5,  0, 0, 0, 1, 1));
        rvecs.push_back(mk(1, 8'h82, 4'h0, 211, 212, 5, 3, 21, 0, 1, 1, 2, 2));
        rvecs.push_back(mk(1, 8'h82, 4'h0, 211, 212, 5, 3, 21, 0, 0, 0, 2, 2));

        rst = 1'b1;
        id_valid = 1'b0; id_ctrl = '0; id_alu = '0; id_rs1d = '0; id_rs2d = '0;
        id_imm = '0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; flush = 1'b0;
        #2;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // rebuild ex_valid=1 with count 2, then reset between edges
        rst = 1'b1;
        #1;
        rst = 1'b0;
        foreach (rvecs[i]) apply_vec(rvecs[i], 100 + i);
        check("pre_reset_valid", {155'd0, ex_valid}, {155'd0, 1'b1});
        check("pre_reset_cnt", {140'd0, cnt}, {140'd0, 16'd2});
        id_valid = 1'b1; id_ctrl = 8'h82; id_rs1 = 5'd21; id_rd = 5'd22;
        rst = 1'b1;
        #2;
        check_zero("async_reset");
        rst = 1'b0;
        apply_vec(mk(1, 8'hA0, 4'h5, 300, 301, 4, 5, 6, 0, 0, 0, 0, 0), 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
